// File: rtl/frame_line_tracker.sv
// Field line counter with interlaced frame-line mapping, frame numbering and
// field timing supervision (length and parity alternation) that drives a lock flag.
module frame_line_tracker #(
    parameter int LINE_WIDTH        = 10,
    parameter int FIELD_LINES_MIN   = 312,
    parameter int FIELD_LINES_MAX   = 313,
    parameter int FIELD_ORDER       = 0,
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int LOCK_FIELDS       = 4
) (
    input  logic                         pixelClockX6,
    input  logic                         nReset,
    input  logic                         pixelClockX1_en,
    input  logic                         lineStart,
    input  logic                         fieldStart,
    input  logic                         isFieldOdd,
    output logic [LINE_WIDTH-1:0]        fieldLine,
    output logic [LINE_WIDTH:0]          frameLine,
    output logic [FRAME_COUNT_WIDTH-1:0] frameNumber,
    output logic                         frameStart,
    output logic                         locked,
    output logic                         fieldError
);

    localparam logic [LINE_WIDTH-1:0] LINE_MAX   = {LINE_WIDTH{1'b1}};
    localparam logic [3:0]            LOCK_COUNT = 4'(LOCK_FIELDS);
    // Parity of the field that opens a frame; that field carries the even frame lines.
    localparam logic                  FIRST_PARITY = (FIELD_ORDER == 0);

    function automatic logic [3:0] sat_good(input logic [3:0] count);
        return (count >= LOCK_COUNT) ? LOCK_COUNT : count + 4'd1;
    endfunction

    function automatic logic [LINE_WIDTH:0] map_line(input logic [LINE_WIDTH-1:0] line,
                                                     input logic parity);
        return {line, parity ^ FIRST_PARITY};
    endfunction

    logic                  parity;
    logic                  overflow;
    logic                  seen_field;
    logic [3:0]            good_count;

    logic [LINE_WIDTH-1:0] line_next;
    logic                  parity_next;
    logic                  line_saturated;
    logic [LINE_WIDTH:0]   field_len;
    logic                  len_ok;
    logic                  field_good;
    logic                  frame_first;
    logic [3:0]            good_next;

    assign field_len   = {1'b0, fieldLine} + 1'b1;
    assign len_ok      = (int'(field_len) >= FIELD_LINES_MIN) &&
                         (int'(field_len) <= FIELD_LINES_MAX);
    assign field_good  = len_ok && !overflow && (isFieldOdd != parity);
    assign frame_first = (isFieldOdd == FIRST_PARITY);
    assign good_next   = sat_good(good_count);

    // fieldStart takes precedence over a coincident lineStart.
    always_comb begin
        line_next      = fieldLine;
        parity_next    = parity;
        line_saturated = 1'b0;
        if (fieldStart) begin
            line_next   = '0;
            parity_next = isFieldOdd;
        end else if (lineStart) begin
            if (fieldLine == LINE_MAX) begin
                line_saturated = 1'b1;
            end else begin
                line_next = fieldLine + 1'b1;
            end
        end
    end

    always_ff @(posedge pixelClockX6) begin
        if (!nReset) begin
            fieldLine   <= '0;
            frameLine   <= '0;
            frameNumber <= '0;
            frameStart  <= 1'b0;
            locked      <= 1'b0;
            fieldError  <= 1'b0;
            good_count  <= '0;
            parity      <= 1'b0;
            overflow    <= 1'b0;
            seen_field  <= 1'b0;
        end else if (pixelClockX1_en) begin
            frameStart <= 1'b0;
            fieldError <= 1'b0;
            if (fieldStart || lineStart) begin
                fieldLine <= line_next;
                frameLine <= map_line(line_next, parity_next);
                parity    <= parity_next;
            end
            if (fieldStart) begin
                overflow   <= 1'b0;
                seen_field <= 1'b1;
                if (frame_first) begin
                    frameStart  <= 1'b1;
                    frameNumber <= frameNumber + 1'b1;
                end
                // The first field after reset has no known start, so it is not judged.
                if (seen_field) begin
                    if (field_good) begin
                        good_count <= good_next;
                        locked     <= (good_next == LOCK_COUNT);
                    end else begin
                        fieldError <= 1'b1;
                        good_count <= '0;
                        locked     <= 1'b0;
                    end
                end
            end else if (line_saturated) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
